click_hit_detector: RTL

- Parametrised click detector for the VGA pipeline, placed after the object renderers.
- On a left-button press it latches the mouse position and waits for the raster to reach that pixel.
- At that pixel it samples the rendered colour and the object tag, then reports a hit (with object id) or a miss.
- Supports several objects, a configurable set of excluded colours, and either level or toggle selection mode.

---
 rtl/click_hit_detector.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/click_hit_detector.sv
// click_hit_detector
// Sits after the object renderers in the VGA pipeline. A left-button press
// latches the mouse position, then the block waits for the raster to reach
// that pixel. At that pixel it samples the rendered colour and the object tag
// and reports either a hit (with object id) or a miss. MODE 0 holds the
// selection only while the button is held. MODE 1 toggles one select bit per
// object on each hit.
module click_hit_detector #(
    parameter int                 COLOR_W      = 12,
    parameter int                 NUM_OBJ      = 4,
    parameter int                 OBJ_W        = 3,
    parameter int                 MODE         = 0,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h888,
    parameter logic [COLOR_W-1:0] BLNK_COLOR   = 12'h000,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = 12'h00f
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [10:0]        hcount_in,
    input  logic [10:0]        vcount_in,
    input  logic [11:0]        xpos_mouse,
    input  logic [11:0]        ypos_mouse,
    input  logic               mouse_left,
    input  logic [COLOR_W-1:0] rgb_in,
    input  logic [OBJ_W-1:0]   obj_id_in,
    output logic               clicked,
    output logic               click_pulse,
    output logic               miss_pulse,
    output logic [OBJ_W-1:0]   hit_id,
    output logic [NUM_OBJ-1:0] sel_vec,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [OBJ_W-1:0] MAX_ID = OBJ_W'(NUM_OBJ);

    state_t             state;
    logic               mouse_left_q;
    logic [11:0]        x_lat;
    logic [11:0]        y_lat;
    logic [1:0]         frame_cnt;

    logic               press_edge;
    logic               pos_match;
    logic               frame_start;
    logic               color_ok;
    logic               id_ok;
    logic               hit_ok;
    logic [NUM_OBJ-1:0] id_onehot;

    // Zero-extending the raster counters means that latched coordinates
    // of 2048 or more never match. Those presses can only end by
    // frame-count timeout or by release.
    always_comb begin
        press_edge  = mouse_left & ~mouse_left_q;
        pos_match   = (x_lat == {1'b0, hcount_in}) && (y_lat == {1'b0, vcount_in});
        frame_start = (vcount_in == 11'd0) && (hcount_in == 11'd0);
        color_ok    = (rgb_in != BG_COLOR) && (rgb_in != BLNK_COLOR) && (rgb_in != BORDER_COLOR);
        id_ok       = (obj_id_in != '0) && (obj_id_in <= MAX_ID);
        hit_ok      = pos_match && color_ok && id_ok;
    end

    // Decode the sampled object tag so that bit k-1 stands for object k.
    always_comb begin
        id_onehot = '0;
        for (int k = 0; k < NUM_OBJ; k++) begin
            id_onehot[k] = (obj_id_in == OBJ_W'(k + 1));
        end
    end

    // Main FSM. All outputs are registered, so a hit or miss shows up
    // one pclk after the matching pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            mouse_left_q <= 1'b0;
            x_lat        <= '0;
            y_lat        <= '0;
            frame_cnt    <= '0;
            clicked      <= 1'b0;
            click_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            hit_id       <= '0;
            sel_vec      <= '0;
        end else begin
            mouse_left_q <= mouse_left;
            click_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        x_lat     <= xpos_mouse;
                        y_lat     <= ypos_mouse;
                        frame_cnt <= '0;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (!mouse_left) begin
                        state <= IDLE;
                        if (MODE == 0) begin
                            sel_vec <= '0;
                        end
                    end else if (pos_match) begin
                        state <= HELD;
                        if (hit_ok) begin
                            click_pulse <= 1'b1;
                            clicked     <= 1'b1;
                            hit_id      <= obj_id_in;
                            if (MODE == 0) begin
                                sel_vec <= id_onehot;
                            end else begin
                                sel_vec <= sel_vec ^ id_onehot;
                            end
                        end else begin
                            miss_pulse <= 1'b1;
                        end
                    end else if (frame_start) begin
                        if (frame_cnt == 2'd1) begin
                            miss_pulse <= 1'b1;
                            state      <= HELD;
                        end else begin
                            frame_cnt <= frame_cnt + 2'd1;
                        end
                    end
                end
                HELD: begin
                    if (!mouse_left) begin
                        state   <= IDLE;
                        clicked <= 1'b0;
                        if (MODE == 0) begin
                            sel_vec <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ARMED);

endmodule
